// File: rtl/fact_scheduler.sv
// rtl/fact_scheduler.sv - round-robin scheduler sharing one factorial engine among NREQ requesters
module fact_scheduler #(
  parameter int NREQ     = 4,
  parameter int N_WIDTH  = 8,
  parameter int FN_WIDTH = 32,
  parameter int TIMEOUT  = 300
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*N_WIDTH-1:0]   n_in,
  output logic [NREQ-1:0]           ack,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [FN_WIDTH-1:0]       rsp_fn,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      eng_start,
  output logic [N_WIDTH-1:0]        eng_n,
  input  logic                      eng_done,
  input  logic [FN_WIDTH-1:0]       eng_fn
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

  state_t              state, state_nxt;
  logic [IW-1:0]       rr_ptr, idx_q, win_idx;
  logic                win_vld;
  logic [N_WIDTH-1:0]  win_n, op_q;
  logic [FN_WIDTH-1:0] res_q;
  logic                err_q;
  logic [CW-1:0]       cnt_q;
  logic                timed_out;

  // First asserted request at or above the pointer, wrapping around.
  always_comb begin
    int j;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!win_vld && req[j]) begin
        win_vld = 1'b1;
        win_idx = IW'(j);
      end
    end
    win_n = n_in[int'(win_idx)*N_WIDTH +: N_WIDTH];
  end

  assign timed_out = (cnt_q >= CW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    ack       = '0;
    rsp_valid = '0;
    rsp_fn    = '0;
    rsp_err   = 1'b0;
    busy      = (state != IDLE);
    eng_start = 1'b0;
    eng_n     = '0;
    case (state)
      IDLE: begin
        if (win_vld && !rst) begin
          ack[win_idx] = 1'b1;
          state_nxt    = (win_n == '0) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        eng_start = 1'b1;
        eng_n     = op_q;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        eng_n = op_q;
        if (timed_out)     state_nxt = RESP;
        else if (!eng_done) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        eng_n = op_q;
        if (eng_done || timed_out) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid[idx_q] = 1'b1;
        rsp_fn           = res_q;
        rsp_err          = err_q;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      idx_q  <= '0;
      op_q   <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (win_vld) begin
            idx_q  <= win_idx;
            op_q   <= win_n;
            rr_ptr <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            err_q  <= 1'b0;
            // 0! needs no engine, so the result is known at grant time.
            res_q  <= (win_n == '0) ? FN_WIDTH'(1) : '0;
          end
        end
        ISSUE: cnt_q <= '0;
        WAIT_BUSY, WAIT_DONE: begin
          cnt_q <= cnt_q + 1'b1;
          if (state == WAIT_DONE && eng_done) begin
            res_q <= eng_fn;
          end else if (timed_out) begin
            res_q <= '0;
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/fact_scheduler.md
FACT_SCHEDULER -- requirements
Module: fact_scheduler

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one factorial engine.
REQ-002 Parameter N_WIDTH, default 8: operand width.
REQ-003 Parameter FN_WIDTH, default 32: result width.
REQ-004 Parameter TIMEOUT, default 300: maximum cycles allowed for one engine job.
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 req  in  NREQ  per-requester request; requester holds req and its operand stable until acked.
REQ-008 n_in  in  NREQ*N_WIDTH  packed operands; requester i occupies bits [i*N_WIDTH +: N_WIDTH].
REQ-009 ack  out  NREQ  one-hot, one-cycle grant/accept pulse.
REQ-010 rsp_valid  out  NREQ  one-hot, one-cycle result pulse to the granted requester.
REQ-011 rsp_fn  out  FN_WIDTH  result; valid only while any rsp_valid bit is high.
REQ-012 rsp_err  out  1  high with rsp_valid when the job timed out.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 eng_start  out  1  start to the engine.
REQ-015 eng_n  out  N_WIDTH  operand to the engine; held from ISSUE until the job ends.
REQ-016 eng_done  in  1  engine ready/done; high when the engine is idle, low while computing.
REQ-017 eng_fn  in  FN_WIDTH  engine result; valid when eng_done returns high.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE and RESP.
REQ-019 IDLE with any req high: ack the winner that cycle, capture its operand and index, advance the RR pointer to winner+1 mod NREQ.
REQ-020 Arbitration SHALL be round-robin, searching upward from the RR pointer with wrap-around.
REQ-021 From IDLE, a captured operand of 0 SHALL go directly to RESP with rsp_fn=1 and SHALL NOT start the engine.
REQ-022 From IDLE, a nonzero captured operand SHALL go to ISSUE.
REQ-023 ISSUE lasts one cycle: eng_start=1, eng_n=captured operand; next state is WAIT_BUSY.
REQ-024 WAIT_BUSY remains until eng_done=0, then goes to WAIT_DONE.
REQ-025 WAIT_DONE remains until eng_done=1, then captures eng_fn into the result register and goes to RESP.
REQ-026 RESP lasts one cycle: rsp_valid[idx]=1 and rsp_fn=result; next state is IDLE.
REQ-027 Arbitration SHALL resume in the cycle after RESP, so at most one job is in flight.
REQ-028 Total latency from ack to rsp_valid = engine cycles + 3; for n=0 it is exactly 1 cycle.
REQ-029 A job cycle counter SHALL clear at ISSUE and increment in WAIT_BUSY and WAIT_DONE.
REQ-030 Timeout: counter reaching TIMEOUT goes to RESP with rsp_err=1 and rsp_fn=0.
REQ-031 Results wider than FN_WIDTH SHALL be passed through as the engine truncates them (mod 2^FN_WIDTH); no overflow flag.
REQ-032 A req still high after its ack SHALL be treated as a new request.
REQ-033 Changes on req while busy SHALL have no effect until IDLE.
REQ-034 eng_start SHALL be high only in ISSUE.

Reset
REQ-035 On rst, the FSM SHALL enter IDLE, the RR pointer SHALL be 0, and the counter, captured index, operand and result SHALL be 0.
REQ-036 On rst, ack, rsp_valid, rsp_err, busy and eng_start SHALL be 0, and rsp_fn and eng_n SHALL be 0.
REQ-037 rst mid-job SHALL abort with no rsp_valid; the first request after reset waits for eng_done=1 in WAIT_DONE as normal.

Verification
REQ-038 req[0]=1, n=5, engine model -> ack[0] pulse, eng_start once with eng_n=5, then rsp_valid[0], rsp_fn=120, rsp_err=0.
REQ-039 req[2]=1, n=0 -> ack[2], then rsp_valid[2] the next cycle with rsp_fn=1; eng_start never asserted.
REQ-040 req[0], req[1] and req[3] all high from reset, each re-requesting after its response -> grant order 0,1,3,0,1,3.
REQ-041 n=12 -> rsp_fn=479001600; n=13 -> rsp_fn=1932053504 (truncated).
REQ-042 Engine model holds eng_done=1 forever after start -> after TIMEOUT cycles, rsp_valid with rsp_err=1 and rsp_fn=0; next request is served.
REQ-043 rst asserted in WAIT_DONE -> all outputs 0 next cycle, no rsp_valid; following n=4 job returns 24.
